textvram_port_arb: RTL
======================

# textvram_port_arb

Single-clock scheduler for the B port of the 4096x8 text VRAM. It shares that port between three requesters, in fixed priority order:
- the video character fetcher (reads, highest priority)
- the host bus (reads and writes)
- an internal screen-fill engine (writes)

The A port is not controlled by this block. All memory-side outputs are registered, and the BRAM read path has no output register.

## Interface
Parameters:
- ADDR_W, 12, VRAM address width
- DATA_W, 8, VRAM data width
- FILL_LEN, 2400, number of cells written by one fill (80x30), range 1..2**ADDR_W

Ports:
- clk  in  1  system clock; all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- vid_req  in  1  fetch request for vid_addr; no handshake, always served
- vid_addr  in  ADDR_W  fetch address
- vid_valid  out  1  vid_data valid this cycle
- vid_data  out  DATA_W  fetched character (combinational from mem_dout)
- host_req  in  1  host access request; held with its fields until host_ack
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_ack  out  1  one-cycle pulse: request issued to memory
- host_rvalid  out  1  host_rdata valid (reads only)
- host_rdata  out  DATA_W  read data (combinational from mem_dout)
- fill_start  in  1  pulse: start filling cells 0..FILL_LEN-1
- fill_char  in  DATA_W  fill value, sampled on the accepted fill_start
- fill_busy  out  1  fill in progress
- fill_done  out  1  one-cycle pulse after the last fill write is issued
- mem_addr  out  ADDR_W  to VRAM addrb
- mem_din  out  DATA_W  to VRAM dib
- mem_we  out  1  to VRAM web
- mem_dout  in  DATA_W  from VRAM dob

## Operation
Arbitration:
- Evaluated every cycle over the current inputs.
- Priority order: vid_req, then host_req (if not already acked), then fill (fill_busy).
- Exactly one grant per cycle, or none.

Grants:
- The winner's address, data and write enable are registered into mem_addr, mem_din and mem_we at the same edge.
- With no grant: mem_we = 0; mem_addr and mem_din hold their previous values.

Video:
- Never stalled.
- Continuous vid_req starves host and fill for as long as it is held; this is accepted behaviour.

Host:
- host_ack is asserted on the edge where the host request is granted.
- The requester drops or changes host_req the cycle after host_ack. A request still high the cycle after ack is a new request.

Fill FSM (IDLE, RUN):
- IDLE -> RUN on fill_start: latch fill_char, set the counter to 0, assert fill_busy.
- In RUN, each fill grant writes fill_char to counter address, then increments the counter.
- The grant with counter = FILL_LEN-1 returns the FSM to IDLE, clears fill_busy and pulses fill_done.
- fill_start while in RUN is ignored.

Fill collisions:
- Host writes during a fill are allowed; the last write to a cell wins.
- A host write to a cell not yet filled is later overwritten by the fill.

Read-return tracking:
- A 2-deep pipeline of source tags (NONE/VID/HOST/FILL) steers vid_valid and host_rvalid.
- Host writes and fill writes produce no return.

## Timing
- Request sampled high at edge N (granted): mem_* driven from N, BRAM captures at N+1, mem_dout valid between N+1 and N+2.
- vid_valid is high in the cycle after edge N+1 for every granted vid_req. Fetch latency is therefore 2 edges, fully pipelined at one fetch per cycle.
- host_rvalid follows the same timing relative to host_ack.
- Host throughput is at most one access per 2 cycles, because acked requests are re-presented only after the ack.
- Fill with an idle port: FILL_LEN cycles from fill_start to fill_done. Each video grant inserted during the fill adds one cycle.
- Reset values (async on rst_n low):
  - all outputs 0, mem_addr 0
  - FSM IDLE, counter 0
  - tag pipeline NONE
- Reset asserted mid-fill or with a read in flight: the fill is abandoned and no vid_valid or host_rvalid is produced for in-flight reads.

## Configuration
- TEXTVRAM_FILL_EN defined: the fill engine and FILL grant are present as described.
- TEXTVRAM_FILL_EN undefined: no fill logic is built. fill_busy and fill_done are tied 0, fill_start and fill_char are ignored, and arbitration is video over host only.

## Structure
- Package textvram_pkg:
  - ADDR_W and DATA_W defaults
  - src_t enum {SRC_NONE, SRC_VID, SRC_HOST, SRC_FILL} for grants and return tags
- Sub-module textvram_fill:
  - contains the fill FSM and counter
  - outputs: busy, the current address/data, done
  - input: grant
  - instantiated only under TEXTVRAM_FILL_EN.

## Test plan
- Read returns: preload 0x123=0x41; vid_req addr 0x123 for one cycle. Required: vid_valid exactly 2 edges later with vid_data=0x41; no host_rvalid.
- Host write/read: host write 0x7FF=0x5A, then host read 0x7FF. Required: host_ack one cycle each; host_rvalid 2 edges after the read ack with 0x5A.
- Collision: vid_req and host_req in the same cycle. Required: video granted first; host_ack exactly one cycle later; both return correct data.
- Fill: fill_start, fill_char=0x20, idle port. Required:
  - fill_done after 2400 cycles
  - cells 0..2399 read 0x20; cell 2400 unchanged
  - a second fill_start mid-run has no effect
- Fill plus video: fill with vid_req high every other cycle. Required: fill takes 2400 + (number of video grants) cycles; no video fetch delayed or lost.
- Reset mid-operation: rst_n low mid-fill with a host read in flight. Required: all outputs 0 immediately; no host_rvalid after release; fill_busy 0.

Source files
------------

// File: rtl/textvram_pkg.sv
// textvram_pkg: shared widths and the source/tag encoding for the text VRAM B-port scheduler.
package textvram_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 12;
  localparam int unsigned DATA_W_DEFAULT = 8;

  // Used both for the per-cycle grant and for the read-return tag pipeline.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_VID,
    SRC_HOST,
    SRC_FILL
  } src_t;

endpackage

// File: rtl/textvram_fill.sv
// textvram_fill: screen-fill engine. Walks cells 0..FILL_LEN-1, advancing one cell per grant.
// Only instantiated when TEXTVRAM_FILL_EN is defined.
module textvram_fill #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned FILL_LEN = 2400
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] value,
  input  logic              grant,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              done
);

  typedef enum logic {StIdle, StRun} state_t;

  localparam logic [ADDR_W-1:0] LastCnt = ADDR_W'(FILL_LEN - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] data_q;
  logic              busy_q;
  logic              done_q;

  // Fill FSM: latch the value on start, step the cell counter on each grant, pulse done at the end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            cnt_q   <= '0;
            data_q  <= value;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          // A start pulse while running is deliberately ignored.
          if (grant) begin
            if (cnt_q == LastCnt) begin
              state_q <= StIdle;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign addr = cnt_q;
  assign data = data_q;
  assign done = done_q;

endmodule

// File: rtl/textvram_port_arb.sv
// textvram_port_arb: fixed-priority scheduler for the text VRAM B port
// (video fetch > host > screen fill). Memory-side outputs are registered; read data is taken
// straight from the unregistered BRAM output and steered by a 2-deep source-tag pipeline.
// Build option: define TEXTVRAM_FILL_EN to include the screen-fill engine.
module textvram_port_arb
  import textvram_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W   = DATA_W_DEFAULT,
  parameter int unsigned FILL_LEN = 2400
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_char,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  src_t              grant;
  src_t              tag_next;
  src_t              tag0_q;
  src_t              tag1_q;
  logic              fill_pending;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_din_q;
  logic              mem_we_q;
  logic              host_ack_q;

`ifdef TEXTVRAM_FILL_EN
  textvram_fill #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .FILL_LEN(FILL_LEN)
  ) u_fill (
    .clk  (clk),
    .rst_n(rst_n),
    .start(fill_start),
    .value(fill_char),
    .grant(grant == SRC_FILL),
    .busy (fill_pending),
    .addr (fill_addr),
    .data (fill_data),
    .done (fill_done)
  );
`else
  logic unused_fill;
  assign unused_fill  = ^{fill_start, fill_char, FILL_LEN[0]};
  assign fill_pending = 1'b0;
  assign fill_addr    = '0;
  assign fill_data    = '0;
  assign fill_done    = 1'b0;
`endif

  assign fill_busy = fill_pending;

  // Fixed-priority pick; a host request in its ack cycle is the one already served.
  always_comb begin
    grant = SRC_NONE;
    if (vid_req) begin
      grant = SRC_VID;
    end else if (host_req && !host_ack_q) begin
      grant = SRC_HOST;
    end else if (fill_pending) begin
      grant = SRC_FILL;
    end
  end

  // Only reads produce a return; writes enter the tag pipeline as NONE.
  always_comb begin
    tag_next = grant;
    if ((grant == SRC_HOST && host_we) || grant == SRC_FILL) begin
      tag_next = SRC_NONE;
    end
  end

  // Register the winner onto the memory port and advance the return-tag pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      host_ack_q <= 1'b0;
      tag0_q     <= SRC_NONE;
      tag1_q     <= SRC_NONE;
    end else begin
      mem_we_q   <= 1'b0;
      host_ack_q <= (grant == SRC_HOST);
      tag0_q     <= tag_next;
      tag1_q     <= tag0_q;
      unique case (grant)
        SRC_NONE: ;
        SRC_VID: begin
          mem_addr_q <= vid_addr;
        end
        SRC_HOST: begin
          mem_addr_q <= host_addr;
          mem_din_q  <= host_wdata;
          mem_we_q   <= host_we;
        end
        SRC_FILL: begin
          mem_addr_q <= fill_addr;
          mem_din_q  <= fill_data;
          mem_we_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_we   = mem_we_q;
  assign host_ack = host_ack_q;

  assign vid_valid   = (tag1_q == SRC_VID);
  assign host_rvalid = (tag1_q == SRC_HOST);
  // Gate the shared BRAM output so each consumer only sees its own returns.
  assign vid_data    = vid_valid ? mem_dout : '0;
  assign host_rdata  = host_rvalid ? mem_dout : '0;

endmodule
